// File: rtl/dut_io_stream_unpack_pkg.sv
// ============================================================================
// dut_io_stream_unpack_pkg: shared sizing helpers and output FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package dut_io_stream_unpack_pkg;

  localparam int DEF_WORD_W = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } out_state_e;

  function automatic int ceil_words(input int bits, input int word_w);
    return (bits + word_w - 1) / word_w;
  endfunction

  function automatic int ptr_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dut_io_stream_unpack_streamer.sv
// ============================================================================
// dut_out_snapshot_streamer: captures the DUT output vector, bursts it as words
// Rev 1.0
// ============================================================================
`default_nettype none

module dut_out_snapshot_streamer
  import dut_io_stream_unpack_pkg::*;
#(
  parameter int DUT_OUT_W = 256,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DUT_OUT_W-1:0] dut_out_vec,
  input  logic                 capture,
  output logic [WORD_W-1:0]    out_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 capture_ovr
);

  localparam int OUT_WORDS = ceil_words(DUT_OUT_W, WORD_W);
  localparam int OUT_PTR_W = ptr_width(OUT_WORDS);
  localparam int SNAP_W    = OUT_WORDS * WORD_W;
  localparam logic [OUT_PTR_W-1:0] LAST_PTR = OUT_PTR_W'(OUT_WORDS - 1);

  out_state_e             state_q, state_d;
  logic [SNAP_W-1:0]      snap_q, snap_d;
  logic [OUT_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0]      out_word_q, out_word_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   ovr_q, ovr_d;

  logic [SNAP_W-1:0]      w_padded;
  logic [OUT_PTR_W-1:0]   w_next_ptr;
  logic [WORD_W-1:0]      w_next_word;

  // Bits above DUT_OUT_W in the last word always read back as zero.
  always_comb begin
    w_padded = '0;
    w_padded[DUT_OUT_W-1:0] = dut_out_vec;
  end

  assign w_next_ptr = rd_ptr_q + OUT_PTR_W'(1);

  always_comb begin
    w_next_word = '0;
    for (int i = 0; i < OUT_WORDS; i++) begin
      if (w_next_ptr == OUT_PTR_W'(i)) begin
        w_next_word = snap_q[i*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      rd_ptr_q    <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      rd_ptr_q    <= rd_ptr_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    rd_ptr_d    = rd_ptr_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    ovr_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          snap_d      = w_padded;
          rd_ptr_d    = '0;
          out_word_d  = w_padded[WORD_W-1:0];
          out_valid_d = 1'b1;
          out_last_d  = (OUT_WORDS == 1);
          state_d     = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // A capture arriving mid-burst, including on the final beat, is dropped.
        ovr_d = capture;
        if (out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            rd_ptr_d   = w_next_ptr;
            out_word_d = w_next_word;
            out_last_d = (w_next_ptr == LAST_PTR);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_word    = out_word_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign capture_ovr = ovr_q;

endmodule

`default_nettype wire

// File: rtl/dut_io_stream_unpack.sv
// ============================================================================
// dut_io_stream_unpack: word-stream fill/commit of DUT inputs, burst readback
// Rev 1.0
// ============================================================================
`default_nettype none

module dut_io_stream_unpack
  import dut_io_stream_unpack_pkg::*;
#(
  parameter int DUT_IN_W  = 256,
  parameter int DUT_OUT_W = 256,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_W-1:0]    in_word,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_ptr_clr,
  input  logic                 commit,
  output logic [DUT_IN_W-1:0]  dut_in_vec,
  input  logic [DUT_OUT_W-1:0] dut_out_vec,
  input  logic                 capture,
  output logic [WORD_W-1:0]    out_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 capture_ovr
);

  localparam int IN_WORDS = ceil_words(DUT_IN_W, WORD_W);
  localparam int IN_PTR_W = ptr_width(IN_WORDS);
  localparam int SHADOW_W = IN_WORDS * WORD_W;
  localparam logic [IN_PTR_W-1:0] LAST_WR = IN_PTR_W'(IN_WORDS - 1);

  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic [IN_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic                full_q, full_d;
  logic [DUT_IN_W-1:0] dut_in_q, dut_in_d;
  logic                w_accept;

  assign w_accept = in_valid && !full_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      wr_ptr_q <= '0;
      full_q   <= 1'b0;
      dut_in_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      wr_ptr_q <= wr_ptr_d;
      full_q   <= full_d;
      dut_in_q <= dut_in_d;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    wr_ptr_d = wr_ptr_q;
    full_d   = full_q;
    dut_in_d = dut_in_q;
    for (int i = 0; i < IN_WORDS; i++) begin
      if (w_accept && (wr_ptr_q == IN_PTR_W'(i))) begin
        shadow_d[i*WORD_W +: WORD_W] = in_word;
      end
    end
    // Commit samples the post-write shadow so a same-cycle beat is included.
    if (commit) begin
      dut_in_d = shadow_d[DUT_IN_W-1:0];
      wr_ptr_d = '0;
      full_d   = 1'b0;
    end else if (in_ptr_clr) begin
      wr_ptr_d = '0;
      full_d   = 1'b0;
    end else if (w_accept) begin
      if (wr_ptr_q == LAST_WR) begin
        full_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + IN_PTR_W'(1);
      end
    end
  end

  assign in_ready   = !full_q;
  assign dut_in_vec = dut_in_q;

  dut_out_snapshot_streamer #(
    .DUT_OUT_W (DUT_OUT_W),
    .WORD_W    (WORD_W)
  ) u_streamer (
    .clk         (clk),
    .reset_n     (reset_n),
    .dut_out_vec (dut_out_vec),
    .capture     (capture),
    .out_word    (out_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .capture_ovr (capture_ovr)
  );

endmodule

`default_nettype wire

// File: tb/tb_dut_io_stream_unpack.sv
// ============================================================================
// tb_dut_io_stream_unpack: scoreboard bench for the stream adapter
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dut_io_stream_unpack;

  localparam int IN_W  = 40;
  localparam int OUT_W = 72;
  localparam int WW    = 32;
  localparam int BIG_W = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [WW-1:0]    in_word = '0;
  logic             in_valid = 1'b0, in_ready, in_ptr_clr = 1'b0, commit = 1'b0;
  logic [IN_W-1:0]  dut_in_vec;
  logic [OUT_W-1:0] dut_out_vec = '0;
  logic             capture = 1'b0;
  logic [WW-1:0]    out_word;
  logic             out_valid, out_ready = 1'b0, out_last, capture_ovr;

  logic [WW-1:0]    b_in_word = '0;
  logic             b_in_valid = 1'b0, b_in_ready, b_in_ptr_clr = 1'b0, b_commit = 1'b0;
  logic [BIG_W-1:0] b_dut_in_vec;
  logic [BIG_W-1:0] b_dut_out_vec = '0;
  logic [WW-1:0]    b_out_word;
  logic             b_out_valid, b_out_last, b_capture_ovr;

  dut_io_stream_unpack #(.DUT_IN_W(IN_W), .DUT_OUT_W(OUT_W), .WORD_W(WW)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready), .in_ptr_clr(in_ptr_clr), .commit(commit),
    .dut_in_vec(dut_in_vec), .dut_out_vec(dut_out_vec), .capture(capture),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .capture_ovr(capture_ovr)
  );

  dut_io_stream_unpack #(.DUT_IN_W(BIG_W), .DUT_OUT_W(BIG_W), .WORD_W(WW)) u_big (
    .clk(clk), .reset_n(reset_n), .in_word(b_in_word), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_ptr_clr(b_in_ptr_clr), .commit(b_commit),
    .dut_in_vec(b_dut_in_vec), .dut_out_vec(b_dut_out_vec), .capture(1'b0),
    .out_word(b_out_word), .out_valid(b_out_valid), .out_ready(1'b1),
    .out_last(b_out_last), .capture_ovr(b_capture_ovr)
  );

  int checks = 0;
  int errors = 0;
  logic [WW:0]      out_q[$];
  logic [IN_W-1:0]  in_q[$];
  logic [BIG_W-1:0] big_q[$];
  bit               ready_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic [OUT_W-1:0] vec);
    logic [3*WW-1:0] pad;
    pad = '0;
    pad[OUT_W-1:0] = vec;
    for (int k = 0; k < 3; k++) out_q.push_back({(k == 2), pad[k*WW +: WW]});
  endtask

  task automatic drain(input bit bp, input bit cap_on_last, input string name);
    logic [WW-1:0] held;
    logic [WW:0]   exp;
    bit            stalled;
    int            k;
    held = '0;
    stalled = 0;
    k = 0;
    while (out_q.size() != 0 && k < 50) begin
      out_ready = bp ? ready_pat[k % 4] : 1'b1;
      if (stalled) begin
        checks++;
        if (out_word !== held) begin
          errors++;
          $display("FAIL %s_hold out_word=%h required %h", name, out_word, held);
        end
      end
      stalled = 0;
      if (out_valid && out_ready) begin
        exp = out_q.pop_front();
        checks++;
        if ({out_last, out_word} !== exp) begin
          errors++;
          $display("FAIL %s_beat last/word=%0b/%h required %0b/%h",
                   name, out_last, out_word, exp[WW], exp[WW-1:0]);
        end
        if (cap_on_last && exp[WW]) capture = 1'b1;
      end else if (out_valid) begin
        stalled = 1;
        held = out_word;
      end
      k++;
      tick();
      if (capture) begin
        capture = 1'b0;
        checks++;
        if (capture_ovr !== 1'b1) begin
          errors++;
          $display("FAIL %s_ovr_on_last capture_ovr=%b required 1", name, capture_ovr);
        end
      end
    end
    out_ready = 1'b0;
    if (out_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout beats_left=%0d required 0", name, out_q.size());
      out_q.delete();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid_after out_valid=%b required 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({in_ready, out_valid, out_last, capture_ovr} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl rdy/vld/last/ovr=%b required 1000",
               {in_ready, out_valid, out_last, capture_ovr});
    end
    checks++;
    if (dut_in_vec !== '0 || out_word !== '0) begin
      errors++;
      $display("FAIL reset_data dut_in_vec=%h out_word=%h required 0", dut_in_vec, out_word);
    end
    checks++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_last !== 1'b0 ||
        b_capture_ovr !== 1'b0 || b_dut_in_vec !== '0 || b_out_word !== '0) begin
      errors++;
      $display("FAIL reset_big in_ready=%b out_valid=%b dut_in_vec=%h required 1/0/0",
               b_in_ready, b_out_valid, b_dut_in_vec);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_commit();
    in_valid = 1'b1;
    in_word  = 32'hDEADBEEF;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_ready1 in_ready=%b required 1", in_ready);
    end
    in_word = 32'h000000A5;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL fill_full in_ready=%b required 0", in_ready);
      end
      tick();
    end
    commit = 1'b1;
    in_q.push_back(40'hA5DEADBEEF);
    tick();
    commit = 1'b0;
    checks++;
    if (dut_in_vec !== in_q.pop_front()) begin
      errors++;
      $display("FAIL commit_vec dut_in_vec=%h required a5deadbeef", dut_in_vec);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL commit_ready in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_commit_writethrough();
    logic [IN_W-1:0] exp;
    in_valid = 1'b1;
    in_word  = 32'h01020304;
    commit   = 1'b1;
    in_q.push_back(40'hA501020304);
    tick();
    commit = 1'b0;
    exp = in_q.pop_front();
    checks++;
    if (dut_in_vec !== exp) begin
      errors++;
      $display("FAIL writethrough dut_in_vec=%h required %h", dut_in_vec, exp);
    end
    in_word = 32'h55667788;
    tick();
    in_valid = 1'b0;
    commit = 1'b1;
    in_q.push_back(40'hA555667788);
    tick();
    commit = 1'b0;
    exp = in_q.pop_front();
    checks++;
    if (dut_in_vec !== exp) begin
      errors++;
      $display("FAIL ptr_after_commit dut_in_vec=%h required %h", dut_in_vec, exp);
    end
  endtask

  task automatic test_ptr_clr();
    logic [BIG_W-1:0] exp;
    b_in_valid = 1'b1;
    b_in_word = 32'hA0A0A0A0;
    tick();
    b_in_word = 32'hA1A1A1A1;
    tick();
    b_in_word = 32'hA2A2A2A2;
    b_in_ptr_clr = 1'b1;
    tick();
    b_in_ptr_clr = 1'b0;
    b_in_word = 32'h12345678;
    tick();
    b_in_valid = 1'b0;
    b_commit = 1'b1;
    exp = '0;
    exp[95:0] = {32'hA2A2A2A2, 32'hA1A1A1A1, 32'h12345678};
    big_q.push_back(exp);
    tick();
    b_commit = 1'b0;
    exp = big_q.pop_front();
    checks++;
    if (b_dut_in_vec !== exp) begin
      errors++;
      $display("FAIL ptr_clr_vec dut_in_vec[95:0]=%h required %h", b_dut_in_vec[95:0], exp[95:0]);
    end
  endtask

  task automatic test_capture_burst();
    dut_out_vec = 72'h11_22334455_66778899;
    capture = 1'b1;
    push_burst(dut_out_vec);
    tick();
    capture = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || capture_ovr !== 1'b0) begin
      errors++;
      $display("FAIL capture_latency out_valid=%b ovr=%b required 1/0", out_valid, capture_ovr);
    end
    drain(1'b0, 1'b0, "burst");
  endtask

  task automatic test_backpressure();
    dut_out_vec = 72'hAB_CAFEF00D_0BADC0DE;
    capture = 1'b1;
    push_burst(dut_out_vec);
    tick();
    capture = 1'b0;
    drain(1'b1, 1'b0, "bp");
  endtask

  task automatic test_overrun();
    dut_out_vec = 72'h5A_01234567_89ABCDEF;
    capture = 1'b1;
    push_burst(dut_out_vec);
    tick();
    capture = 1'b0;
    dut_out_vec = 72'hFF_FFFFFFFF_FFFFFFFF;
    out_ready = 1'b0;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    checks++;
    if (capture_ovr !== 1'b1) begin
      errors++;
      $display("FAIL ovr_pulse capture_ovr=%b required 1", capture_ovr);
    end
    tick();
    checks++;
    if (capture_ovr !== 1'b0) begin
      errors++;
      $display("FAIL ovr_width capture_ovr=%b required 0", capture_ovr);
    end
    drain(1'b0, 1'b1, "ovr");
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    in_word = 32'h77777777;
    repeat (2) tick();
    in_valid = 1'b0;
    dut_out_vec = 72'h33_44444444_55555555;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || dut_in_vec === '0) begin
      errors++;
      $display("FAIL arst_pre in_ready=%b out_valid=%b dut_in_vec=%h required 0/1/nonzero",
               in_ready, out_valid, dut_in_vec);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_in_vec !== '0) begin
      errors++;
      $display("FAIL arst_async out_valid=%b in_ready=%b dut_in_vec=%h required 0/1/0",
               out_valid, in_ready, dut_in_vec);
    end
    #1;
    reset_n = 1'b1;
    tick();
    dut_out_vec = 72'h01_02030405_06070809;
    capture = 1'b1;
    push_burst(dut_out_vec);
    tick();
    capture = 1'b0;
    drain(1'b0, 1'b0, "post_rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill_commit();
    test_commit_writethrough();
    test_ptr_clr();
    test_capture_burst();
    test_backpressure();
    test_overrun();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
